// File: rtl/multi_channel_command_decoder_if.sv
// multi_channel_command_decoder_if: UART byte streams plus per-channel DDS word, set and enable bus.
interface multi_channel_command_decoder_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
);
  logic                      received;
  logic [7:0]                rx_byte;
  logic                      tx_busy;
  logic                      transmit;
  logic [7:0]                tx_byte;
  logic [CHANNELS*WIDTH-1:0] m;
  logic [CHANNELS-1:0]       set;
  logic [CHANNELS-1:0]       en;
  logic                      err;
  modport master (output received, rx_byte, tx_busy, input transmit, tx_byte, m, set, en, err);
  modport slave  (input received, rx_byte, tx_busy, output transmit, tx_byte, m, set, en, err);
endinterface

// File: rtl/multi_channel_command_decoder.sv
// multi_channel_command_decoder: UART commands load a shadow word, commit it to DDS channels, and read channels back.
module multi_channel_command_decoder #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 12000
) (
  input logic clk,
  input logic rst_n,
  multi_channel_command_decoder_if.slave bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, TX_LOAD, TX_WAIT} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    words_q [CHANNELS];
  logic [WIDTH-1:0]    words_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [CHANNELS-1:0] en_q, en_d, set_q, set_d, sel;
  logic                err_q, err_d, transmit_q, transmit_d, guard_q, guard_d, ch_ok, byte_ok;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [4:0]          idx_q, idx_d, cnt_q, cnt_d, arg;
  logic [CW-1:0]       ch_q, ch_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [2:0]          op;
  always_comb begin
    op         = bus.rx_byte[7:5];
    arg        = bus.rx_byte[4:0];
    sel        = op == 3'b101 ? '1 : CHANNELS'(1) << arg;
    ch_ok      = 32'(arg) < CHANNELS;
    byte_ok    = 32'(arg) < NBYTES;
    state_d    = state_q;
    words_d    = words_q;
    shadow_d   = shadow_q;
    en_d       = en_q;
    set_d      = '0;
    err_d      = 1'b0;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    guard_d    = guard_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    tmr_d      = tmr_q;
    case (state_q)
      IDLE: if (bus.received) begin
        case (op)
          3'b000: if (byte_ok) begin
            idx_d   = arg;
            tmr_d   = TW'(TIMEOUT);
            state_d = WAIT_DATA;
          end else err_d = 1'b1;
          3'b001, 3'b101: if (ch_ok || op[2]) begin
            for (int k = 0; k < CHANNELS; k++) words_d[k] = sel[k] ? shadow_q : words_q[k];
            set_d = sel;
          end else err_d = 1'b1;
          3'b010: if (ch_ok) en_d = en_q | sel; else err_d = 1'b1;
          3'b011: if (ch_ok) en_d = en_q & ~sel; else err_d = 1'b1;
          3'b100: if (ch_ok) begin
            ch_d    = CW'(arg);
            cnt_d   = '0;
            state_d = TX_LOAD;
          end else err_d = 1'b1;
          default: err_d = 1'b1;
        endcase
      end
      // a data byte landing on the expiry cycle still wins over the timeout
      WAIT_DATA: if (bus.received) begin
        shadow_d = (shadow_q & ~(WIDTH'(8'hFF) << {idx_q, 3'b000})) | (WIDTH'(bus.rx_byte) << {idx_q, 3'b000});
        state_d  = IDLE;
      end else if (tmr_q == '0) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else tmr_d = tmr_q - TW'(1);
      TX_LOAD: begin
        err_d = bus.received;
        if (!bus.tx_busy) begin
          transmit_d = 1'b1;
          tx_byte_d  = 8'(words_q[ch_q] >> {cnt_q, 3'b000});
          guard_d    = 1'b1;
          state_d    = TX_WAIT;
        end
      end
      // the UART raises tx_busy a cycle late, so the first TX_WAIT cycle ignores it
      TX_WAIT: begin
        err_d = bus.received;
        if (guard_q) guard_d = 1'b0;
        else if (!bus.tx_busy) begin
          if (32'(cnt_q) == NBYTES - 1) state_d = IDLE;
          else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      words_q    <= '{default: '0};
      shadow_q   <= '0;
      en_q       <= '0;
      set_q      <= '0;
      err_q      <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      guard_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      words_q    <= words_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      set_q      <= set_d;
      err_q      <= err_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      guard_q    <= guard_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      tmr_q      <= tmr_d;
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_m
    assign bus.m[g*WIDTH +: WIDTH] = words_q[g];
  end
  assign bus.set      = set_q;
  assign bus.en       = en_q;
  assign bus.err      = err_q;
  assign bus.transmit = transmit_q;
  assign bus.tx_byte  = tx_byte_q;
endmodule
